// File: rtl/audio_pkg.sv
// Shared types and sizes for the audio SDRAM read path.
package audio_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, DONE, ABORT, FLUSH} rdr_state_t;

  localparam int BEATS    = 8;
  localparam int SAMPLE_W = 16;
  localparam int WORD_W   = BEATS * SAMPLE_W;
  localparam int CNT_W    = 4;
endpackage

// File: rtl/beat_packer.sv
// Collects returned 16-bit beats into one 128-bit word; the k-th beat of a
// request lands in lane k. Lanes keep their value until overwritten.
module beat_packer
  import audio_pkg::*;
(
  input  logic                Clk50,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                capture_en,
  input  logic                write_en,
  input  logic                beat_valid,
  input  logic [SAMPLE_W-1:0] beat_data,
  output logic [CNT_W-1:0]    recv_cnt,
  output logic [WORD_W-1:0]   word
);
  logic [CNT_W-1:0] recv_cnt_reg;
  logic             take;

  // A beat past the eighth has no lane to land in and is not counted.
  assign take = capture_en & beat_valid & (recv_cnt_reg != CNT_W'(BEATS));

  always_ff @(posedge Clk50) begin
    if (!reset_n)
      recv_cnt_reg <= '0;
    else if (clear)
      recv_cnt_reg <= '0;
    else if (take)
      recv_cnt_reg <= recv_cnt_reg + CNT_W'(1);
  end

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_lane
    logic [SAMPLE_W-1:0] lane_reg;

    always_ff @(posedge Clk50) begin
      if (!reset_n)
        lane_reg <= '0;
      else if (take && write_en && recv_cnt_reg == CNT_W'(gi))
        lane_reg <= beat_data;
    end

    assign word[gi*SAMPLE_W +: SAMPLE_W] = lane_reg;
  end

  assign recv_cnt = recv_cnt_reg;
endmodule

// File: rtl/audio_sdram_reader.sv
// Turns each 128-bit audio read request into eight pipelined 16-bit SDRAM
// reads and returns the packed word with a one-cycle sdram_ac.
module audio_sdram_reader
  import audio_pkg::*;
#(
  parameter int                MEM_AW    = 25,
  parameter logic [MEM_AW-1:0] ADDR_BASE = '0,
  parameter int                TIMEOUT   = 1024
) (
  input  logic                Clk50,
  input  logic                reset_n,
  input  logic                init_done,
  input  logic                sdram_rd,
  input  logic [21:0]         sdram_addr,
  output logic                sdram_Wait,
  output logic                sdram_ac,
  output logic [WORD_W-1:0]   sdram_data,
  output logic                mem_read,
  output logic [MEM_AW-1:0]   mem_address,
  input  logic                mem_waitrequest,
  input  logic [SAMPLE_W-1:0] mem_readdata,
  input  logic                mem_readdatavalid,
  output logic                rd_err
);
  localparam int               TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

  rdr_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  iss_cnt_reg;
  logic [CNT_W-1:0]  recv_cnt;
  logic [TMR_W-1:0]  timer_reg;
  logic [MEM_AW-1:0] base_reg;
  logic              rd_err_reg;
  logic              start;
  logic              timeout_hit;
  logic              issue_ok;
  logic              capture_en;
  logic              write_en;

  assign timeout_hit = (timer_reg == TMR_LAST);
  assign issue_ok    = (state_reg == ISSUE) && !mem_waitrequest;

  // Timeout is checked first so it wins over any other exit condition.
  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sdram_rd && init_done) begin
          start      = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (timeout_hit)
          state_next = ABORT;
        else if (issue_ok && iss_cnt_reg == CNT_LAST)
          state_next = DRAIN;
      end
      DRAIN: begin
        if (timeout_hit)
          state_next = ABORT;
        else if (recv_cnt == CNT_FULL)
          state_next = DONE;
      end
      DONE:  state_next = IDLE;
      ABORT: state_next = FLUSH;
      FLUSH: begin
        if (recv_cnt == iss_cnt_reg || timeout_hit)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk50) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      iss_cnt_reg <= '0;
      timer_reg   <= '0;
      base_reg    <= '0;
      rd_err_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start) begin
        base_reg    <= ADDR_BASE + MEM_AW'({sdram_addr, 3'b000});
        iss_cnt_reg <= '0;
      end else if (issue_ok) begin
        iss_cnt_reg <= iss_cnt_reg + CNT_W'(1);
      end
      // The same timer bounds the request and, restarted, the flush.
      if (start || state_reg == ABORT)
        timer_reg <= '0;
      else if (timer_reg != TMR_MAX)
        timer_reg <= timer_reg + TMR_W'(1);
      if (state_next == ABORT)
        rd_err_reg <= 1'b1;
    end
  end

  assign capture_en = (state_reg == ISSUE) || (state_reg == DRAIN) ||
                      (state_reg == ABORT) || (state_reg == FLUSH);
  assign write_en   = (state_reg == ISSUE) || (state_reg == DRAIN);

  beat_packer u_packer (
    .Clk50      (Clk50),
    .reset_n    (reset_n),
    .clear      (start),
    .capture_en (capture_en),
    .write_en   (write_en),
    .beat_valid (mem_readdatavalid),
    .beat_data  (mem_readdata),
    .recv_cnt   (recv_cnt),
    .word       (sdram_data)
  );

  assign sdram_Wait  = ~init_done | (state_reg != IDLE);
  assign sdram_ac    = (state_reg == DONE) || (state_reg == ABORT);
  assign mem_read    = (state_reg == ISSUE);
  assign mem_address = mem_read ? (base_reg + MEM_AW'(iss_cnt_reg)) : '0;
  assign rd_err      = rd_err_reg;
endmodule

// File: tb/tb_audio_sdram_reader.sv
// Directed bench for audio_sdram_reader: memory model with read latency 2,
// optional waitrequest toggling and beat hold-back, plus an I2S player loop.
module tb_audio_sdram_reader;
  localparam int TO  = 64;
  localparam int LAT = 2;

  logic         Clk50 = 1'b0;
  logic         reset_n = 1'b0;
  logic         init_done = 1'b0;
  logic         sdram_rd = 1'b0;
  logic [21:0]  sdram_addr = '0;
  logic         sdram_Wait;
  logic         sdram_ac;
  logic [127:0] sdram_data;
  logic         mem_read;
  logic [24:0]  mem_address;
  logic         mem_waitrequest = 1'b0;
  logic [15:0]  mem_readdata = '0;
  logic         mem_readdatavalid = 1'b0;
  logic         rd_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ac_total = 0;
  int ac_norq = 0;
  bit wait_mode = 1'b0;
  bit mem_hold = 1'b0;
  int hold_from = 8;
  logic [24:0] pend_addr[$];
  int          pend_due[$];
  logic [24:0] iss_addr[$];
  int          iss_cyc[$];

  audio_sdram_reader #(.MEM_AW(25), .ADDR_BASE(25'h0), .TIMEOUT(TO)) dut (
    .Clk50             (Clk50),
    .reset_n           (reset_n),
    .init_done         (init_done),
    .sdram_rd          (sdram_rd),
    .sdram_addr        (sdram_addr),
    .sdram_Wait        (sdram_Wait),
    .sdram_ac          (sdram_ac),
    .sdram_data        (sdram_data),
    .mem_read          (mem_read),
    .mem_address       (mem_address),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdata      (mem_readdata),
    .mem_readdatavalid (mem_readdatavalid),
    .rd_err            (rd_err)
  );

  always #10 Clk50 = ~Clk50;

  function automatic logic [15:0] mem_word(input logic [24:0] a);
    return a[15:0] ^ 16'h0080;
  endfunction

  // Command acceptance at the clock edge; beat returned LAT edges later.
  always @(posedge Clk50) begin
    cyc <= cyc + 1;
    if (mem_read && !mem_waitrequest) begin
      pend_addr.push_back(mem_address);
      pend_due.push_back(cyc + LAT);
      iss_addr.push_back(mem_address);
      iss_cyc.push_back(cyc);
    end
  end

  always @(negedge Clk50) begin
    mem_waitrequest <= wait_mode ? ~mem_waitrequest : 1'b0;
    if (pend_addr.size() != 0 && pend_due[0] <= cyc &&
        !(mem_hold && int'(pend_addr[0][2:0]) >= hold_from)) begin
      mem_readdata      <= mem_word(pend_addr[0]);
      mem_readdatavalid <= 1'b1;
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      mem_readdatavalid <= 1'b0;
    end
  end

  always @(negedge Clk50) begin
    if (sdram_ac) begin
      ac_total <= ac_total + 1;
      if (!sdram_rd) ac_norq <= ac_norq + 1;
    end
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Player request: hold rd until ac, capture data, drop rd the cycle after.
  task automatic run_req(input logic [21:0] a, output logic [127:0] d, output int lat);
    int n;
    sdram_addr = a;
    sdram_rd   = 1'b1;
    lat = -1;
    d   = '0;
    n   = 0;
    while (sdram_Wait && n < 200) begin
      @(posedge Clk50); #1;
      n++;
    end
    if (sdram_Wait) begin
      sdram_rd = 1'b0;
      return;
    end
    @(posedge Clk50); #1;
    n = 0;
    while (!sdram_ac && n < 400) begin
      @(posedge Clk50); #1;
      n++;
    end
    if (sdram_ac) begin
      lat = n;
      d   = sdram_data;
    end
    @(posedge Clk50); #1;
    sdram_rd = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge Clk50);
    #1;
    checks++; if (sdram_ac !== 1'b0) begin errors++; $display("FAIL reset_ac: got %b expected 0", sdram_ac); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %b expected 0", mem_read); end
    checks++; if (mem_address !== 25'h0) begin errors++; $display("FAIL reset_mem_address: got %h expected 0", mem_address); end
    checks++; if (sdram_data !== 128'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", sdram_data); end
    checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL reset_rd_err: got %b expected 0", rd_err); end
    checks++; if (sdram_Wait !== 1'b1) begin errors++; $display("FAIL reset_wait: got %b expected 1", sdram_Wait); end
    reset_n = 1'b1;
    @(posedge Clk50); #1;
    init_done = 1'b1;
    #1;
    checks++; if (sdram_Wait !== 1'b0) begin errors++; $display("FAIL ready_wait: got %b expected 0", sdram_Wait); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [127:0] d;
    int lat;
    iss_addr.delete();
    iss_cyc.delete();
    run_req(22'h000010, d, lat);
    checks++; if (lat !== 11) begin errors++; $display("FAIL basic_latency: got %0d expected 11", lat); end
    checks++; if (d !== 128'h0007_0006_0005_0004_0003_0002_0001_0000) begin errors++; $display("FAIL basic_data: got %h expected 0007..0000", d); end
    checks++; if (sdram_data !== d) begin errors++; $display("FAIL basic_hold: got %h expected %h", sdram_data, d); end
    checks++; if (iss_addr.size() != 8) begin errors++; $display("FAIL basic_issue_count: got %0d expected 8", iss_addr.size()); end
    for (int k = 0; k < iss_addr.size() && k < 8; k++) begin
      checks++; if (iss_addr[k] !== 25'h80 + 25'(k)) begin errors++; $display("FAIL basic_addr%0d: got %h expected %h", k, iss_addr[k], 25'h80 + 25'(k)); end
      if (k > 0) begin
        checks++; if (iss_cyc[k] - iss_cyc[k-1] != 1) begin errors++; $display("FAIL basic_consecutive%0d: gap %0d expected 1", k, iss_cyc[k] - iss_cyc[k-1]); end
      end
    end
    checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL basic_rd_err: got %b expected 0", rd_err); end
    $display("test_basic addr=000010 lat=%0d data=%h", lat, d);
  endtask

  task automatic test_waitrequest();
    logic [127:0] d;
    int lat;
    iss_addr.delete();
    iss_cyc.delete();
    wait_mode = 1'b1;
    run_req(22'h000010, d, lat);
    wait_mode = 1'b0;
    checks++; if (d !== 128'h0007_0006_0005_0004_0003_0002_0001_0000) begin errors++; $display("FAIL wr_data: got %h expected 0007..0000", d); end
    checks++; if (iss_addr.size() != 8) begin errors++; $display("FAIL wr_issue_count: got %0d expected 8", iss_addr.size()); end
    for (int k = 0; k < iss_addr.size() && k < 8; k++) begin
      checks++; if (iss_addr[k] !== 25'h80 + 25'(k)) begin errors++; $display("FAIL wr_addr%0d: got %h expected %h", k, iss_addr[k], 25'h80 + 25'(k)); end
    end
    checks++; if (lat <= 11) begin errors++; $display("FAIL wr_latency: got %0d expected above 11", lat); end
    $display("test_waitrequest lat=%0d data=%h", lat, d);
  endtask

  task automatic test_init_gate();
    logic [127:0] d;
    int lat;
    init_done  = 1'b0;
    sdram_addr = 22'h000020;
    sdram_rd   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk50); #1;
      checks++; if (sdram_Wait !== 1'b1) begin errors++; $display("FAIL init_wait%0d: got %b expected 1", i, sdram_Wait); end
      checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL init_mem_read%0d: got %b expected 0", i, mem_read); end
    end
    init_done = 1'b1;
    run_req(22'h000020, d, lat);
    checks++; if (lat !== 11) begin errors++; $display("FAIL init_latency: got %0d expected 11", lat); end
    checks++; if (d !== 128'h0187_0186_0185_0184_0183_0182_0181_0180) begin errors++; $display("FAIL init_data: got %h expected 0187..0180", d); end
    $display("test_init_gate lat=%0d data=%h", lat, d);
  endtask

  task automatic test_timeout();
    logic [127:0] d;
    int lat;
    int n;
    hold_from = 5;
    mem_hold  = 1'b1;
    run_req(22'h000002, d, lat);
    checks++; if (lat !== 64) begin errors++; $display("FAIL to_latency: got %0d expected 64", lat); end
    checks++; if (d !== 128'h0187_0186_0185_0094_0093_0092_0091_0090) begin errors++; $display("FAIL to_data: got %h expected 0187_0186_0185_0094..0090", d); end
    checks++; if (rd_err !== 1'b1) begin errors++; $display("FAIL to_rd_err: got %b expected 1", rd_err); end
    checks++; if (sdram_Wait !== 1'b1) begin errors++; $display("FAIL to_flush_wait: got %b expected 1", sdram_Wait); end
    mem_hold = 1'b0;
    n = 0;
    while (sdram_Wait && n < 100) begin
      @(posedge Clk50); #1;
      n++;
    end
    checks++; if (sdram_Wait !== 1'b0) begin errors++; $display("FAIL to_wait_release: got %b expected 0", sdram_Wait); end
    checks++; if (sdram_data !== 128'h0187_0186_0185_0094_0093_0092_0091_0090) begin errors++; $display("FAIL to_discard: got %h expected unchanged", sdram_data); end
    checks++; if (pend_addr.size() != 0) begin errors++; $display("FAIL to_drained: got %0d pending expected 0", pend_addr.size()); end
    run_req(22'h000003, d, lat);
    checks++; if (d !== 128'h009f_009e_009d_009c_009b_009a_0099_0098) begin errors++; $display("FAIL to_next_data: got %h expected 009f..0098", d); end
    checks++; if (lat !== 11) begin errors++; $display("FAIL to_next_latency: got %0d expected 11", lat); end
    checks++; if (rd_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", rd_err); end
    hold_from = 8;
    $display("test_timeout flush_cycles=%0d next=%h", n, d);
  endtask

  task automatic test_reset_mid();
    hold_from  = 4;
    mem_hold   = 1'b1;
    sdram_addr = 22'h000004;
    sdram_rd   = 1'b1;
    @(posedge Clk50); #1;
    repeat (14) begin
      @(posedge Clk50); #1;
    end
    checks++; if (mem_read !== 1'b0 || sdram_Wait !== 1'b1) begin errors++; $display("FAIL mid_drain: read=%b wait=%b expected 0 1", mem_read, sdram_Wait); end
    checks++; if (sdram_data !== 128'h009f_009e_009d_009c_00a3_00a2_00a1_00a0) begin errors++; $display("FAIL mid_partial: got %h expected 009f_009e_009d_009c_00a3..00a0", sdram_data); end
    reset_n  = 1'b0;
    sdram_rd = 1'b0;
    @(posedge Clk50); #1;
    reset_n = 1'b1;
    checks++; if (sdram_ac !== 1'b0) begin errors++; $display("FAIL mid_ac: got %b expected 0", sdram_ac); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL mid_mem_read: got %b expected 0", mem_read); end
    checks++; if (mem_address !== 25'h0) begin errors++; $display("FAIL mid_mem_address: got %h expected 0", mem_address); end
    checks++; if (sdram_data !== 128'h0) begin errors++; $display("FAIL mid_data: got %h expected 0", sdram_data); end
    checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL mid_rd_err: got %b expected 0", rd_err); end
    checks++; if (sdram_Wait !== 1'b0) begin errors++; $display("FAIL mid_wait: got %b expected 0", sdram_Wait); end
    mem_hold = 1'b0;
    repeat (8) begin
      @(posedge Clk50); #1;
    end
    checks++; if (sdram_data !== 128'h0) begin errors++; $display("FAIL mid_stale: got %h expected 0", sdram_data); end
    checks++; if (pend_addr.size() != 0) begin errors++; $display("FAIL mid_drained: got %0d pending expected 0", pend_addr.size()); end
    hold_from = 8;
    $display("test_reset_mid done");
  endtask

  task automatic test_back_to_back();
    logic [127:0] d;
    logic [127:0] e;
    logic [127:0] fifo[$];
    logic [127:0] expq[$];
    logic [21:0]  a;
    logic [24:0]  wa;
    int lat;
    int ac_base;
    ac_base = ac_total;
    for (int i = 0; i < 200; i++) begin
      a = 22'(i * 13 + 5);
      wait_mode = (i >= 100);
      run_req(a, d, lat);
      fifo.push_back(d);
      e = '0;
      for (int k = 0; k < 8; k++) begin
        wa = {a, 3'b000} + 25'(k);
        e[16*k +: 16] = mem_word(wa);
      end
      expq.push_back(e);
      if (i % 2 == 1) begin
        @(posedge Clk50); #1;
      end
    end
    wait_mode = 1'b0;
    for (int i = 0; i < 200; i++) begin
      checks++; if (fifo[i] !== expq[i]) begin errors++; $display("FAIL b2b_word%0d: got %h expected %h", i, fifo[i], expq[i]); end
    end
    checks++; if (ac_total - ac_base != 200) begin errors++; $display("FAIL b2b_ac_count: got %0d expected 200", ac_total - ac_base); end
    checks++; if (ac_norq != 0) begin errors++; $display("FAIL b2b_ac_without_rd: got %0d expected 0", ac_norq); end
    $display("test_back_to_back requests=200 acs=%0d", ac_total - ac_base);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_waitrequest();
    test_init_gate();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
